// File: rtl/digit_demux4.sv
`default_nettype none
// ============================================================================
// Module   : digit_demux4
// Purpose  : Registered 1-to-4 nibble demultiplexer with double buffering.
//            Incoming nibbles land in a shadow bank; the shadow bank is
//            copied to the output bank on commit. The display therefore
//            never sees a half-updated frame.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous active-high reset
//            wr_en_i      - write strobe, one nibble per cycle
//            wr_sel_i     - target channel in manual mode
//            wr_data_i    - nibble to write
//            auto_i       - 1: address from internal pointer, 0: wr_sel_i
//            ptr_clr_i    - resync pointer / force address 0
//            commit_i     - copy shadow bank to output bank
//            ch0_o..ch3_o - committed channel values
//            wr_ptr_o     - current internal pointer
//            pending_o    - shadow written since last commit
//            frame_done_o - one-cycle pulse following a commit edge
// Revision : 1.0 - initial release
// ============================================================================
module digit_demux4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [1:0] wr_sel_i,
  input  logic [3:0] wr_data_i,
  input  logic       auto_i,
  input  logic       ptr_clr_i,
  input  logic       commit_i,
  output logic [3:0] ch0_o,
  output logic [3:0] ch1_o,
  output logic [3:0] ch2_o,
  output logic [3:0] ch3_o,
  output logic [1:0] wr_ptr_o,
  output logic       pending_o,
  output logic       frame_done_o
);

  localparam int unsigned NUM_CH = 4;
  localparam logic [1:0]  LAST_CH = 2'd3;

  logic [3:0] shadow_q [NUM_CH];
  logic [3:0] shadow_d [NUM_CH];
  logic [3:0] out_q    [NUM_CH];
  logic [3:0] out_d    [NUM_CH];
  logic [1:0] ptr_q, ptr_d;
  logic       pending_q, pending_d;
  logic       frame_done_q, frame_done_d;

  logic [1:0] w_addr;
  logic       w_do_commit;

  // ptr_clr overrides the address source in both modes.
  assign w_addr = ptr_clr_i ? 2'd0 : (auto_i ? ptr_q : wr_sel_i);

  // An auto write to the last channel closes the frame by itself. With
  // ptr_clr the address is 0, so a resync write never auto-commits.
  assign w_do_commit = commit_i | (wr_en_i & auto_i & (w_addr == LAST_CH));

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      always_comb begin
        shadow_d[i] = shadow_q[i];
        if (wr_en_i && (w_addr == i[1:0])) begin
          shadow_d[i] = wr_data_i;
        end
        // Copying the post-write shadow value forwards this cycle's write
        // straight to the output on a committing edge.
        out_d[i] = w_do_commit ? shadow_d[i] : out_q[i];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_q[i] <= 4'h0;
          out_q[i]    <= 4'h0;
        end else begin
          shadow_q[i] <= shadow_d[i];
          out_q[i]    <= out_d[i];
        end
      end
    end
  endgenerate

  always_comb begin
    ptr_d = ptr_q;
    if (ptr_clr_i && wr_en_i && auto_i) begin
      // The resync write itself consumed channel 0.
      ptr_d = 2'd1;
    end else if (ptr_clr_i) begin
      ptr_d = 2'd0;
    end else if (wr_en_i && auto_i) begin
      ptr_d = ptr_q + 2'd1;
    end

    pending_d = pending_q;
    if (w_do_commit) begin
      pending_d = 1'b0;
    end else if (wr_en_i) begin
      pending_d = 1'b1;
    end

    frame_done_d = w_do_commit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= 2'd0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ch0_o        = out_q[0];
  assign ch1_o        = out_q[1];
  assign ch2_o        = out_q[2];
  assign ch3_o        = out_q[3];
  assign wr_ptr_o     = ptr_q;
  assign pending_o    = pending_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_demux4.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_demux4
// Purpose  : Self-checking bench for digit_demux4. Directed scenarios plus
//            randomized traffic, compared against a frame-level model of the
//            shadow/output banks.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_demux4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en_i;
  logic [1:0] wr_sel_i;
  logic [3:0] wr_data_i;
  logic       auto_i;
  logic       ptr_clr_i;
  logic       commit_i;
  logic [3:0] ch0_o, ch1_o, ch2_o, ch3_o;
  logic [1:0] wr_ptr_o;
  logic       pending_o;
  logic       frame_done_o;

  int n_err = 0;
  int n_chk = 0;

  // Reference state
  logic [3:0] m_sh  [4];
  logic [3:0] m_out [4];
  int         m_ptr;
  bit         m_pend;
  bit         m_fd;

  always #5 clk = ~clk;

  digit_demux4 dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en_i),
    .wr_sel_i     (wr_sel_i),
    .wr_data_i    (wr_data_i),
    .auto_i       (auto_i),
    .ptr_clr_i    (ptr_clr_i),
    .commit_i     (commit_i),
    .ch0_o        (ch0_o),
    .ch1_o        (ch1_o),
    .ch2_o        (ch2_o),
    .ch3_o        (ch3_o),
    .wr_ptr_o     (wr_ptr_o),
    .pending_o    (pending_o),
    .frame_done_o (frame_done_o)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = 4'h0;
      m_out[i] = 4'h0;
    end
    m_ptr  = 0;
    m_pend = 0;
    m_fd   = 0;
  endtask

  // One clock of the frame model: write into the shadow bank, then a commit
  // publishes the whole (already updated) shadow bank.
  task automatic model_tick(input bit we, input int sel, input logic [3:0] d,
                            input bit au, input bit pc, input bit cm);
    int  a;
    bit  publish;
    a = pc ? 0 : (au ? m_ptr : sel);
    publish = cm || (we && au && a == 3);
    if (we) m_sh[a] = d;
    if (publish) begin
      for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
    end
    if (publish)  m_pend = 0;
    else if (we)  m_pend = 1;
    m_fd = publish;
    if (pc)       m_ptr = (we && au) ? 1 : 0;
    else if (we && au) m_ptr = (m_ptr + 1) % 4;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ch0"}, {4'h0, ch0_o}, {4'h0, m_out[0]});
    chk({tag, ".ch1"}, {4'h0, ch1_o}, {4'h0, m_out[1]});
    chk({tag, ".ch2"}, {4'h0, ch2_o}, {4'h0, m_out[2]});
    chk({tag, ".ch3"}, {4'h0, ch3_o}, {4'h0, m_out[3]});
    chk({tag, ".ptr"}, {6'h0, wr_ptr_o}, 8'(m_ptr));
    chk({tag, ".pend"}, {7'h0, pending_o}, {7'h0, m_pend});
    chk({tag, ".fd"}, {7'h0, frame_done_o}, {7'h0, m_fd});
  endtask

  // Drive one cycle, clock it, then compare 1 time unit after the edge.
  task automatic drive(input string tag, input bit we, input int sel,
                       input logic [3:0] d, input bit au, input bit pc, input bit cm);
    wr_en_i   = we;
    wr_sel_i  = 2'(sel);
    wr_data_i = d;
    auto_i    = au;
    ptr_clr_i = pc;
    commit_i  = cm;
    @(posedge clk);
    model_tick(we, sel, d, au, pc, cm);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en_i = 0; wr_sel_i = 0; wr_data_i = 0;
    auto_i = 0; ptr_clr_i = 0; commit_i = 0;
    model_reset();
    @(posedge clk);
    #1;
    async_reset("rst0");

    // Auto frame 1,2,3,4
    drive("af1", 1, 0, 4'h1, 1, 0, 0);
    chk("af1.ch0_hold", {4'h0, ch0_o}, 8'h00);
    drive("af2", 1, 0, 4'h2, 1, 0, 0);
    drive("af3", 1, 0, 4'h3, 1, 0, 0);
    chk("af3.ch2_hold", {4'h0, ch2_o}, 8'h00);
    drive("af4", 1, 0, 4'h4, 1, 0, 0);
    chk("af4.val", {ch0_o, ch1_o}, 8'h12);
    chk("af4.val2", {ch2_o, ch3_o}, 8'h34);
    chk("af4.fd", {7'h0, frame_done_o}, 8'h01);
    drive("af_idle", 0, 0, 4'h0, 1, 0, 0);
    chk("af_idle.fd", {7'h0, frame_done_o}, 8'h00);

    // Manual with forwarding
    drive("man1", 1, 2, 4'hA, 0, 0, 0);
    chk("man1.ch2_keep", {4'h0, ch2_o}, 8'h03);
    chk("man1.pend", {7'h0, pending_o}, 8'h01);
    drive("man2", 1, 1, 4'h5, 0, 0, 1);
    chk("man2.ch12", {ch1_o, ch2_o}, 8'h5A);
    chk("man2.pend", {7'h0, pending_o}, 8'h00);

    // Pointer resync
    drive("rs1", 1, 0, 4'h6, 1, 0, 0);
    drive("rs2", 1, 0, 4'h6, 1, 0, 0);
    chk("rs2.ptr", {6'h0, wr_ptr_o}, 8'h02);
    drive("rs3", 1, 3, 4'h7, 1, 1, 0);
    chk("rs3.ptr", {6'h0, wr_ptr_o}, 8'h01);
    chk("rs3.no_commit", {7'h0, frame_done_o}, 8'h00);
    drive("rs4", 0, 0, 4'h0, 0, 0, 1);
    chk("rs4.ch0", {4'h0, ch0_o}, 8'h07);

    // Reset mid-frame, then clean frame
    drive("rm1", 1, 0, 4'h9, 1, 0, 0);
    drive("rm2", 1, 0, 4'h8, 1, 0, 0);
    async_reset("rm_rst");
    drive("rm3", 1, 0, 4'hC, 1, 0, 0);
    drive("rm4", 1, 0, 4'hD, 1, 0, 0);
    drive("rm5", 1, 0, 4'hE, 1, 0, 0);
    drive("rm6", 1, 0, 4'hF, 1, 0, 0);
    chk("rm6.val", {ch0_o, ch1_o}, 8'hCD);
    chk("rm6.val2", {ch2_o, ch3_o}, 8'hEF);

    // Idle back-to-back commits
    drive("ic1", 0, 0, 4'h0, 0, 0, 1);
    drive("ic2", 0, 0, 4'h0, 0, 0, 1);
    chk("ic2.fd", {7'h0, frame_done_o}, 8'h01);
    chk("ic2.val", {ch0_o, ch3_o}, 8'hCF);
    drive("ic3", 0, 0, 4'h0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive("rnd",
            bit'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 3)),
            4'($urandom),
            bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 9) == 0),
            bit'($urandom_range(0, 7) == 0));
      if (n == 200) async_reset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digit_demux4.md
# digit_demux4

Registered 1-to-4 nibble demultiplexer with double buffering. It is the write side of the four-channel digit path: it accepts a stream of 4-bit values and distributes them into four channel registers, `ch0`–`ch3`. Those registers feed the 4:1 display selector. Writes land in a shadow bank and become visible on the outputs only on commit, so the display never shows a half-updated frame.

## Interface
Parameters:
- none (fixed 4 channels × 4 bits)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  write strobe; one nibble per cycle when high
- `wr_sel`  in  2  target channel in manual mode; ignored when `auto` = 1
- `wr_data`  in  4  nibble to write
- `auto`  in  1  1 = address from internal pointer; 0 = address from `wr_sel`
- `ptr_clr`  in  1  resync internal pointer to channel 0
- `commit`  in  1  copy shadow bank to output bank (manual mode; also honoured in auto mode)
- `ch0`, `ch1`, `ch2`, `ch3`  out  4 each  committed channel values
- `wr_ptr`  out  2  current internal pointer
- `pending`  out  1  shadow differs from last commit (written since last commit)
- `frame_done`  out  1  one-cycle pulse, registered, marks a commit

## Operation
- State:
  - `shadow[0..3]`: 4 bits each
  - `out_bank[0..3]`: 4 bits each, drives `chN`
  - `ptr`: 2 bits
  - `pending`: 1 bit
  - `frame_done`: 1 bit
- Reset, asynchronous with `rst` high: all shadow and out_bank entries = 4'h0; `ptr` = 0; `pending` = 0; `frame_done` = 0.
  - Reset mid-frame discards partial writes.
- Write address:
  - `addr` = `ptr_clr` ? 0 : (`auto` ? `ptr` : `wr_sel`).
  - `ptr_clr` forces address 0 in both modes.
- Write, `wr_en` = 1: `shadow[addr]` ← `wr_data`; `pending` ← 1.
- Pointer update, in priority order:
  1. `ptr_clr` & `wr_en` & `auto` → `ptr` ← 1.
  2. `ptr_clr` otherwise → `ptr` ← 0.
  3. `wr_en` & `auto` → `ptr` ← `ptr` + 1, wrapping 3 → 0.
  4. Otherwise `ptr` holds.
  - Manual writes never move `ptr`.
- Commit trigger: `do_commit` = `commit` | (`wr_en` & `auto` & `addr` == 3).
- On `do_commit`:
  - each `out_bank[i]` ← `shadow[i]`, except the entry being written this cycle, which takes `wr_data` (write-through forwarding);
  - `pending` ← 0, overriding a same-cycle write;
  - `frame_done` ← 1 for exactly one cycle.
- `commit` with no prior writes still copies and still pulses `frame_done`.
- Back-to-back commits each pulse `frame_done`, so it stays high on consecutive cycles.
- `auto` may change on any cycle. It takes effect for that cycle's address; `ptr` keeps its value across mode changes.

## Timing
- Write-to-output latency:
  - a write committed in cycle N appears on `chN` after edge N (same edge as the write when forwarded);
  - an uncommitted write never appears on `chN`.
- `frame_done` is high in the cycle after the commit edge, aligned with new `chN` values.
- `wr_ptr` and `pending` are registered and reflect the post-edge state.
- Full throughput: one write per cycle; a 4-nibble auto frame completes in 4 cycles with no bubbles.
- No stall or backpressure; every strobe is accepted.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all `chN` = 0, `wr_ptr` = 0, `pending` = 0, `frame_done` = 0 immediately, without waiting for a clock edge.
- Auto frame: `auto` = 1, write 4'h1, 4'h2, 4'h3, 4'h4 on consecutive cycles →
  - `chN` hold 0 for the first three writes;
  - after the 4th edge, `ch0..3` = 1, 2, 3, 4;
  - `frame_done` pulses once; `wr_ptr` = 0; `pending` = 0.
- Manual with forwarding: `auto` = 0, write `wr_sel` = 2 / 4'hA with `commit` = 0 → `pending` = 1, `ch2` unchanged. Then write `wr_sel` = 1 / 4'h5 with `commit` = 1 in the same cycle → `ch1` = 5, `ch2` = A, `pending` = 0, `frame_done` pulses.
- Pointer resync: `auto` = 1, two writes (`wr_ptr` = 2), then `ptr_clr` with write 4'h7 → `shadow[0]` = 7, `wr_ptr` = 1, and no auto-commit.
- Reset mid-frame: `auto` = 1, write 4'h9, 4'h8, assert `rst`, release, then write a full frame 4'hC, 4'hD, 4'hE, 4'hF → outputs = C, D, E, F, and no stale 9/8 appears on any output.
- Idle commit: pulse `commit` twice back-to-back with no writes → `chN` unchanged and `frame_done` high for 2 consecutive cycles.
